// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Small microprogram sequencer. A 16-entry program memory holds
// {ctl[1:0], opcode[3:0]} entries. After start it walks the program and
// hands one opcode per clock to a CPU, with four entry kinds:
//   SEQ  (00) issue opcode, continue at PC+1 (mod 16)
//   RPTZ (01) issue opcode, then wait one cycle and re-issue until cpu_zf=1
//   WRAP (10) issue opcode, continue at PC 0
//   HALT (11) issue nothing, stop with done=1
//
// Optional feature: define SEQ_WATCHDOG_EN to add an 8-bit repeat counter
// that aborts a runaway RPTZ loop with err=1 after 256 failed zero checks.
// Without the macro err is tied to 0 and RPTZ may repeat indefinitely.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   prog_we    program write strobe (ignored while busy)
//   prog_addr  program write address
//   prog_wdata program entry {ctl[1:0], opcode[3:0]}
//   start      begin a run at PC 0 (from IDLE or DONE)
//   abort      stop a run, return to IDLE (wins over start)
//   cpu_cf     CPU carry flag (reserved, no effect)
//   cpu_zf     CPU zero flag, sampled in CHECK
//   op_code    opcode to the CPU, NOP_CODE when nothing is issued
//   busy       run in progress (ISSUE or CHECK)
//   done       run ended by HALT or watchdog error
//   pc         current program address
//   err        watchdog timeout flag
// -----------------------------------------------------------------------------
module program_sequencer #(
  parameter logic [3:0] NOP_CODE = 4'b0000,
  parameter int         DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [5:0] prog_wdata,
  input  logic       start,
  input  logic       abort,
  input  logic       cpu_cf,
  input  logic       cpu_zf,
  output logic [3:0] op_code,
  output logic       busy,
  output logic       done,
  output logic [3:0] pc,
  output logic       err
);

  localparam logic [1:0] CTL_SEQ  = 2'b00;
  localparam logic [1:0] CTL_RPTZ = 2'b01;
  localparam logic [1:0] CTL_WRAP = 2'b10;
  localparam logic [1:0] CTL_HALT = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic       done_q, done_d;
  logic [5:0] mem_q [DEPTH];

  logic [1:0] cur_ctl;
  logic [3:0] cur_op;

  // Carry flag is reserved for future conditional entries.
  logic unused_cf;
  assign unused_cf = cpu_cf;

  assign cur_ctl = mem_q[pc_q][5:4];
  assign cur_op  = mem_q[pc_q][3:0];

  assign busy    = (state_q == ISSUE) || (state_q == CHECK);
  assign done    = done_q;
  assign pc      = pc_q;

  // Opcode is a pure function of the current state, so an asynchronous
  // reset silences it immediately.
  always_comb begin
    op_code = NOP_CODE;
    if (state_q == ISSUE && cur_ctl != CTL_HALT) begin
      op_code = cur_op;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
`ifdef SEQ_WATCHDOG_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (abort) begin
      // err is deliberately kept so software can still read why a run ended.
      state_d = IDLE;
      pc_d    = 4'd0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = ISSUE;
            pc_d    = 4'd0;
            done_d  = 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_d   = 1'b0;
            cnt_d   = 8'd0;
`endif
          end
        end
        ISSUE: begin
`ifdef SEQ_WATCHDOG_EN
          // Only a repeat of the same RPTZ entry keeps the count; any other
          // entry means the next RPTZ seen is a fresh address.
          if (cur_ctl != CTL_RPTZ) cnt_d = 8'd0;
`endif
          unique case (cur_ctl)
            CTL_SEQ:  pc_d = pc_q + 4'd1;
            CTL_WRAP: pc_d = 4'd0;
            CTL_RPTZ: state_d = CHECK;
            CTL_HALT: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            default:  state_d = IDLE;
          endcase
        end
        CHECK: begin
          if (cpu_zf) begin
            state_d = ISSUE;
            pc_d    = pc_q + 4'd1;
`ifdef SEQ_WATCHDOG_EN
            cnt_d   = 8'd0;
`endif
          end else begin
`ifdef SEQ_WATCHDOG_EN
            if (cnt_q == 8'hFF) begin
              state_d = DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = ISSUE;
              cnt_d   = cnt_q + 8'd1;
            end
`else
            state_d = ISSUE;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // Writes are blocked while busy, so the executing entry can never change
  // underneath the sequencer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {CTL_HALT, NOP_CODE};
      end
    end else if (prog_we && !busy) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam logic [3:0] NOP = 4'b0000;

  logic       clk = 1'b0;
  logic       rstn;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [5:0] prog_wdata;
  logic       start, abort, cpu_cf, cpu_zf;
  logic [3:0] op_code;
  logic       busy, done, err;
  logic [3:0] pc;

  program_sequencer #(.NOP_CODE(NOP), .DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort), .cpu_cf(cpu_cf),
    .cpu_zf(cpu_zf), .op_code(op_code), .busy(busy), .done(done), .pc(pc),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference program image
  logic [1:0] m_ctl [16];
  logic [3:0] m_op  [16];

  // Expected per-cycle activity of one run
  typedef struct {
    logic [3:0] op;
    logic [3:0] pc;
    logic       zf;
  } cyc_t;
  cyc_t exp_q[$];
  bit   zfq[$];
  bit         exp_halted;
  logic [3:0] exp_halt_pc;
  bit         exp_err;

  int         inj_we_cyc    = -1;
  int         inj_start_cyc = -1;
  logic [3:0] inj_addr      = 4'd0;
  logic [5:0] inj_data      = 6'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input int p, input bit z);
    cyc_t c;
    c.op = op; c.pc = 4'(p); c.zf = z;
    exp_q.push_back(c);
  endtask

  function automatic bit next_zf();
    if (zfq.size() > 0) return zfq.pop_front();
    return ($urandom_range(0, 2) != 0);
  endfunction

  // Walk the program the way the CPU would see it: one opcode per issued
  // entry, plus a NOP slot after each RPTZ issue where ZF is examined.
  task automatic build_trace(input int max_len);
    int p;
    int fails;
    bit z;
    bit stop;
    exp_q.delete();
    exp_halted = 0; exp_err = 0; exp_halt_pc = 4'd0;
    p = 0; stop = 0;
    while (!stop && exp_q.size() < max_len) begin
      case (m_ctl[p])
        2'b00: begin push(m_op[p], p, 1'($urandom_range(0, 1))); p = (p + 1) % 16; end
        2'b10: begin push(m_op[p], p, 1'($urandom_range(0, 1))); p = 0; end
        2'b01: begin
          fails = 0;
          forever begin
            push(m_op[p], p, 1'($urandom_range(0, 1)));
            z = next_zf();
            push(NOP, p, z);
            if (z) begin p = (p + 1) % 16; break; end
            fails++;
`ifdef SEQ_WATCHDOG_EN
            if (fails == 256) begin
              exp_err = 1; exp_halted = 1; exp_halt_pc = 4'(p); stop = 1; break;
            end
`endif
            if (exp_q.size() >= max_len) break;
          end
        end
        default: begin
          push(NOP, p, 1'($urandom_range(0, 1)));
          exp_halted = 1; exp_halt_pc = 4'(p); stop = 1;
        end
      endcase
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] c, input logic [3:0] o);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = {c, o};
    m_ctl[a] = c; m_op[a] = o;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_and_check(input string tag);
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start      = (i == inj_start_cyc);
      prog_we    = (i == inj_we_cyc);
      prog_addr  = inj_addr;
      prog_wdata = inj_data;
      cpu_zf     = exp_q[i].zf;
      cpu_cf     = 1'($urandom_range(0, 1));
      chk({tag, ".op"},   8'(op_code), 8'(exp_q[i].op));
      chk({tag, ".pc"},   8'(pc),      8'(exp_q[i].pc));
      chk({tag, ".busy"}, 8'(busy),    8'd1);
      chk({tag, ".done"}, 8'(done),    8'd0);
      chk({tag, ".err"},  8'(err),     8'd0);
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    if (exp_halted) begin
      chk({tag, ".end_done"}, 8'(done),    8'd1);
      chk({tag, ".end_busy"}, 8'(busy),    8'd0);
      chk({tag, ".end_op"},   8'(op_code), 8'(NOP));
      chk({tag, ".end_pc"},   8'(pc),      8'(exp_halt_pc));
      chk({tag, ".end_err"},  8'(err),     8'(exp_err));
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({tag, ".abort_busy"}, 8'(busy),    8'd0);
      chk({tag, ".abort_done"}, 8'(done),    8'd0);
      chk({tag, ".abort_pc"},   8'(pc),      8'd0);
      chk({tag, ".abort_op"},   8'(op_code), 8'(NOP));
      chk({tag, ".abort_err"},  8'(err),     8'(exp_err));
    end
    inj_we_cyc = -1; inj_start_cyc = -1;
  endtask

  initial begin
    rstn = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_wdata = 6'd0;
    start = 1'b0; abort = 1'b0; cpu_cf = 1'b0; cpu_zf = 1'b0;
    for (int i = 0; i < 16; i++) begin m_ctl[i] = 2'b11; m_op[i] = NOP; end

    // Reset state
    #3;
    chk("rst.op",   8'(op_code), 8'(NOP));
    chk("rst.busy", 8'(busy),    8'd0);
    chk("rst.done", 8'(done),    8'd0);
    chk("rst.pc",   8'(pc),      8'd0);
    chk("rst.err",  8'(err),     8'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Straight-line program ending in HALT
    wr(4'd0, 2'b00, 4'b0001);
    wr(4'd1, 2'b00, 4'b0110);
    wr(4'd2, 2'b00, 4'b0100);
    wr(4'd3, 2'b11, 4'b0000);
    build_trace(50);
    run_and_check("seq");

    // Abort wins over start; DONE -> IDLE and stays there
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("prio.busy", 8'(busy), 8'd0);
    chk("prio.done", 8'(done), 8'd0);
    chk("prio.pc",   8'(pc),   8'd0);
    @(negedge clk);
    chk("prio.idle_busy", 8'(busy), 8'd0);

    // RPTZ with ZF = 0, 0, 1
    wr(4'd0, 2'b01, 4'b0100);
    wr(4'd1, 2'b11, 4'b0000);
    zfq = '{1'b0, 1'b0, 1'b1};
    build_trace(50);
    run_and_check("rptz");

    // SEQ + WRAP loops forever until aborted
    wr(4'd0, 2'b00, 4'b0011);
    wr(4'd1, 2'b10, 4'b1010);
    build_trace(9);
    run_and_check("wrap");

    // Writes and start while busy are ignored
    for (int i = 0; i < 5; i++) wr(4'(i), 2'b00, 4'(i + 1));
    wr(4'd5, 2'b00, 4'b0111);
    wr(4'd6, 2'b11, 4'b0000);
    build_trace(50);
    inj_we_cyc = 2; inj_addr = 4'd5; inj_data = {2'b00, 4'b1110};
    inj_start_cyc = 3;
    run_and_check("busy_wr");
    build_trace(50);
    run_and_check("busy_wr_rerun");

    // Runaway RPTZ: watchdog trips, or repeats forever without it
    wr(4'd0, 2'b01, 4'b0100);
    wr(4'd1, 2'b11, 4'b0000);
    zfq.delete();
    for (int i = 0; i < 300; i++) zfq.push_back(1'b0);
    build_trace(600);
    run_and_check("wdog");
    zfq.delete();
    // abort keeps err; the next start clears it
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("wdog.abort_err", 8'(err), 8'(exp_err));
    chk("wdog.abort_pc",  8'(pc),  8'd0);

    // Random programs
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) begin
        int k;
        logic [1:0] c;
        k = $urandom_range(0, 9);
        c = (k < 5) ? 2'b00 : (k < 7) ? 2'b01 : (k < 8) ? 2'b10 : 2'b11;
        wr(4'(a), c, 4'($urandom_range(1, 15)));
      end
      build_trace(60);
      run_and_check("rand");
    end

    // Asynchronous reset mid-run wipes the program back to HALT
    for (int i = 0; i < 4; i++) wr(4'(i), 2'b00, 4'(i + 9));
    wr(4'd4, 2'b11, 4'b0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst.op",   8'(op_code), 8'(NOP));
    chk("arst.busy", 8'(busy),    8'd0);
    chk("arst.done", 8'(done),    8'd0);
    chk("arst.pc",   8'(pc),      8'd0);
    chk("arst.err",  8'(err),     8'd0);
    #6 rstn = 1'b1;
    @(negedge clk);
    chk("arst.after_op",   8'(op_code), 8'(NOP));
    chk("arst.after_busy", 8'(busy),    8'd0);
    for (int i = 0; i < 16; i++) begin m_ctl[i] = 2'b11; m_op[i] = NOP; end
    build_trace(10);
    run_and_check("arst_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
